irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Interrupt controller between the interrupt sources (tc0_irq, tc1_irq, external interrupt, spares) and the Processor.
//  Latches and masks the sources, picks one by fixed priority, and presents it on a req/ack handshake.
//  Keeps the claimed source in service until software writes EOI.
//  Its registers are a word-addressed peripheral on the Bridge, accessed like a TC: Addr/WE/Din/Dout.
// PARAMETERS
//  N_SRC       6    number of sources; src[0] has the highest priority.
//  CLAIM_NONE  7    CLAIM/irq_id code meaning "no source in service"; must be >= N_SRC.
// PORTS
//  clk      in   1      clock.
//  reset    in   1      asynchronous, active-high reset.
//  src      in   N_SRC  raw source lines, synchronous to clk.
//  Addr     in   30     word address [31:2]; only Addr[4:2] is decoded (the Bridge does base select).
//  WE       in   1      register write strobe, one cycle.
//  Din      in   32     write data.
//  Dout     out  32     read data, combinational from Addr.
//  hwint    out  N_SRC  PEND & MASK, for Cause.IP visibility.
//  irq_req  out  1      registered interrupt request to the Processor.
//  irq_id   out  3      registered id of the requested source; valid while irq_req=1.
//  irq_ack  in   1      one-cycle pulse from the Processor when it takes the interrupt.
// BEHAVIOUR
//  Register map (Addr[4:2]):
//   0 PEND   - RO for level bits; W1C for edge bits.
//   1 MASK   - RW; reset 0.
//   2 MODE   - RW; 1 = edge, 0 = level; reset all 1.
//   3 CLAIM  - RO; reset CLAIM_NONE.
//   4 EOI    - WO; writes only take effect in SERVICE.
//   All other offsets read 0 and ignore writes. Unused high bits read 0.
//  Source capture:
//   - src_d <= src every cycle.
//   - Edge bit: PEND sets on src & ~src_d. It clears on W1C or on ack-claim.
//   - A set and a clear in the same cycle: the set wins.
//   - Level bit: PEND <= src, registered. W1C and ack-claim have no effect on it.
//   - Writing MODE takes effect on the next cycle. The PEND bit is not cleared on a mode change.
//  Arbitration: elig = PEND & MASK; best = lowest set index of elig.
//  FSM, registered; reset -> IDLE:
//   IDLE    - irq_req=0. If elig!=0: irq_id<=best, irq_req<=1, go REQ.
//   REQ     - irq_req=1, and irq_id<=best every cycle, so a higher-priority arrival pre-empts the request.
//           - If elig becomes 0 and irq_ack=0: irq_req<=0, go IDLE.
//           - If irq_ack=1: CLAIM<=irq_id (the value presented this cycle), clear that PEND bit if it is edge, irq_req<=0, go SERVICE.
//           - Ack wins over a simultaneous loss of eligibility.
//   SERVICE - irq_req=0; new PEND bits still latch.
//           - An EOI write with Din[2:0]==CLAIM sets CLAIM<=CLAIM_NONE and goes IDLE.
//           - An EOI write with a mismatched value is ignored.
//  irq_ack while in IDLE or SERVICE is ignored.
//  No nesting: at most one source is in service at a time.
//  Latency:
//   - src rises with src_d=0 at edge k -> PEND set after edge k.
//   - If masked in, irq_req=1 after edge k+1.
//   - EOI at edge k -> irq_req=1 again after edge k+1 if anything is still eligible.
//  Reset values (async, any state, including mid-handshake):
//   - irq_req=0, irq_id=0, PEND=0, src_d=0, MASK=0, MODE=all 1, CLAIM=CLAIM_NONE, state=IDLE.
//   - Consequently hwint=0 and Dout=0 for PEND reads.
//  No X on any output after reset.
// TESTING
//  1. MASK=0x3F, pulse src[1] for one cycle -> irq_req=1, irq_id=1 two edges later; PEND reads 0x02.
//  2. During REQ with irq_id=3, raise src[0] -> irq_id=0 next cycle; ack then gives CLAIM=0 and PEND[0]=0.
//  3. In SERVICE with CLAIM=2: EOI Din=5 -> no change. EOI Din=2 -> CLAIM=7 and state IDLE; a pending src[4] is requested on the next edge.
//  4. MODE[2]=0, hold src[2] high, then ack + EOI -> re-requested with irq_id=2 until src[2] drops.
//  5. Same-cycle edge on src[3] and W1C of bit 3 -> PEND[3]=1. MASK cleared while in REQ -> irq_req falls next edge.
//  6. Assert reset while in REQ and while in SERVICE -> all outputs reach reset values immediately; Dout at CLAIM reads 7.

Source files
------------

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches and masks the interrupt sources, picks the
// highest-priority eligible one (lowest index), presents it to the Processor on a
// req/ack handshake, and holds the claimed source in service until software
// writes a matching EOI. The registers are a word-addressed peripheral on the Bridge.
//
// Register map (decoded from Addr[2:0], which is byte address bits [4:2]):
//   0 PEND  - level bits follow src (registered); edge bits are write-1-to-clear
//   1 MASK  - read/write
//   2 MODE  - read/write, 1 = edge, 0 = level
//   3 CLAIM - read-only, id of the source in service or CLAIM_NONE
//   4 EOI   - write-only, reads 0
//   5..7    - read 0, writes ignored
module irq_ctrl #(
  parameter int unsigned N_SRC      = 6,
  parameter int unsigned CLAIM_NONE = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic [29:0]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  output logic [N_SRC-1:0] hwint,
  output logic             irq_req,
  output logic [2:0]       irq_id,
  input  logic             irq_ack
);

  localparam int unsigned IdW = 3;
  localparam logic [IdW-1:0] ClaimNone = IdW'(CLAIM_NONE);

  localparam logic [2:0] OffPend  = 3'd0;
  localparam logic [2:0] OffMask  = 3'd1;
  localparam logic [2:0] OffMode  = 3'd2;
  localparam logic [2:0] OffClaim = 3'd3;
  localparam logic [2:0] OffEoi   = 3'd4;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StReq     = 2'd1;
  localparam logic [1:0] StService = 2'd2;

  // State
  logic [N_SRC-1:0] src_q;      // previous-cycle sample of src, for edge detection
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] mode_q;
  logic [IdW-1:0]   claim_q, claim_d;
  logic [1:0]       state_q, state_d;
  logic             req_q, req_d;
  logic [IdW-1:0]   id_q, id_d;

  // Bus decode
  logic [2:0]       reg_sel;
  logic             wr_pend;
  logic             wr_mask;
  logic             wr_mode;
  logic             wr_eoi;
  logic             eoi_match;

  // Source and arbitration terms
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] ack_clr;
  logic             ack_take;
  logic             any_elig;
  logic [IdW-1:0]   best;

  // Bits of the bus that carry no information for this block.
  logic             unused_bus_bits;

  assign reg_sel   = Addr[2:0];
  assign wr_pend   = WE && (reg_sel == OffPend);
  assign wr_mask   = WE && (reg_sel == OffMask);
  assign wr_mode   = WE && (reg_sel == OffMode);
  assign wr_eoi    = WE && (reg_sel == OffEoi);
  assign eoi_match = wr_eoi && (Din[IdW-1:0] == claim_q);

  assign unused_bus_bits = ^{Addr[29:3], Din[31:N_SRC]};

  assign elig     = pend_q & mask_q;
  assign any_elig = |elig;
  assign rise     = src & ~src_q;
  assign w1c      = wr_pend ? Din[N_SRC-1:0] : '0;

  // The ack only claims while a request is actually being presented.
  assign ack_take = (state_q == StReq) && irq_ack;

  // Fixed priority: the lowest set index of elig wins.
  always_comb begin
    logic found;
    best  = '0;
    found = 1'b0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (elig[i] && !found) begin
        best  = IdW'(i);
        found = 1'b1;
      end
    end
  end

  // One-hot clear of the source being claimed this cycle (the id presented now).
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      ack_clr[i] = ack_take && (id_q == IdW'(i));
    end
  end

  // Pending next state: edge bits hold, clear on W1C/claim, and a new rising edge
  // overrides a same-cycle clear. Level bits simply follow src one cycle late.
  always_comb begin
    pend_d = (mode_q & ((pend_q & ~w1c & ~ack_clr) | rise)) | (~mode_q & src);
  end

  // Request / service sequencing.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    id_d    = id_q;
    claim_d = claim_q;
    case (state_q)
      StIdle: begin
        if (any_elig) begin
          req_d   = 1'b1;
          id_d    = best;
          state_d = StReq;
        end
      end
      StReq: begin
        // An ack takes precedence over a simultaneous loss of eligibility.
        if (irq_ack) begin
          claim_d = id_q;
          req_d   = 1'b0;
          state_d = StService;
        end else if (!any_elig) begin
          req_d   = 1'b0;
          state_d = StIdle;
        end else begin
          // Re-arbitrate every cycle so a higher-priority arrival pre-empts.
          id_d    = best;
        end
      end
      StService: begin
        // A mismatched EOI value is ignored; the source stays in service.
        if (eoi_match) begin
          claim_d = ClaimNone;
          state_d = StIdle;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // Source sampling and pending bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q  <= '0;
      pend_q <= '0;
    end else begin
      src_q  <= src;
      pend_q <= pend_d;
    end
  end

  // Software-writable configuration; MODE writes apply from the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
      mode_q <= '1;
    end else begin
      if (wr_mask) begin
        mask_q <= Din[N_SRC-1:0];
      end
      if (wr_mode) begin
        mode_q <= Din[N_SRC-1:0];
      end
    end
  end

  // Handshake state, registered outputs and the claimed id.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      id_q    <= '0;
      claim_q <= ClaimNone;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      id_q    <= id_d;
      claim_q <= claim_d;
    end
  end

  // Combinational read-back; unused high bits and unmapped offsets read 0.
  always_comb begin
    Dout = '0;
    case (reg_sel)
      OffPend:  Dout[N_SRC-1:0] = pend_q;
      OffMask:  Dout[N_SRC-1:0] = mask_q;
      OffMode:  Dout[N_SRC-1:0] = mode_q;
      OffClaim: Dout[IdW-1:0]   = claim_q;
      default:  Dout = '0;
    endcase
  end

  assign hwint   = elig;
  assign irq_req = req_q;
  assign irq_id  = id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: a register-map vector table, hand-written
// handshake sequences, and randomized traffic checked against a behavioural model.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  src;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic [5:0]  hwint;
  logic        irq_req;
  logic [2:0]  irq_id;
  logic        irq_ack;

  always #5 clk = ~clk;

  irq_ctrl #(
    .N_SRC     (6),
    .CLAIM_NONE(7)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .src    (src),
    .Addr   (Addr),
    .WE     (WE),
    .Din    (Din),
    .Dout   (Dout),
    .hwint  (hwint),
    .irq_req(irq_req),
    .irq_id (irq_id),
    .irq_ack(irq_ack)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [5:0]  src;
    logic [2:0]  raddr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model state: "in service" is simply claim != 7.
  bit [5:0] m_pend, m_mask, m_mode, m_prev;
  int       m_claim;
  bit       m_req;
  int       m_id;

  function automatic vec_t mk(input logic [2:0] a, input logic w, input logic [31:0] d,
                              input logic [5:0] s, input logic [2:0] ra,
                              input logic [31:0] e, input string n);
    vec_t v;
    v.addr = a; v.we = w; v.din = d; v.src = s; v.raddr = ra; v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    WE   = 1'b0;
    Addr = {27'd0, a};
    #1;
    d = Dout;
  endtask

  task automatic chk_rd(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(name, d, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    Addr = {27'd0, a};
    Din  = d;
    WE   = 1'b1;
    tick();
    WE   = 1'b0;
    Din  = '0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    src     = '0;
    WE      = 1'b0;
    Din     = '0;
    Addr    = '0;
    irq_ack = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_mode = '1; m_prev = '0;
    m_claim = 7; m_req = 1'b0; m_id = 0;
  endtask

  task automatic model_step(input bit [5:0] s, input bit we, input int a,
                            input bit [31:0] d, input bit ack);
    int       best;
    bit [5:0] np;
    bit       taken;
    best  = -1;
    for (int i = 0; i < 6; i++) if (m_pend[i] && m_mask[i] && best < 0) best = i;
    taken = m_req && ack;
    for (int i = 0; i < 6; i++) begin
      if (m_mode[i]) begin
        np[i] = m_pend[i];
        if (we && a == 0 && d[i]) np[i] = 1'b0;
        if (taken && m_id == i) np[i] = 1'b0;
        if (s[i] && !m_prev[i]) np[i] = 1'b1;
      end else begin
        np[i] = s[i];
      end
    end
    if (m_claim != 7) begin
      if (we && a == 4 && int'(d[2:0]) == m_claim) m_claim = 7;
    end else if (m_req) begin
      if (ack) begin
        m_claim = m_id;
        m_req   = 1'b0;
      end else if (best < 0) begin
        m_req = 1'b0;
      end else begin
        m_id = best;
      end
    end else if (best >= 0) begin
      m_req = 1'b1;
      m_id  = best;
    end
    m_pend = np;
    if (we && a == 1) m_mask = d[5:0];
    if (we && a == 2) m_mode = d[5:0];
    m_prev = s;
  endtask

  function automatic logic [31:0] model_read(input int a);
    case (a)
      0:       return {26'd0, m_pend};
      1:       return {26'd0, m_mask};
      2:       return {26'd0, m_mode};
      3:       return 32'(m_claim);
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    logic [31:0] d;
    vec_t        v;

    // Register map vectors, applied in order from reset.
    tbl.push_back(mk(3'd0, 1'b0, 32'h0,        6'h00, 3'd1, 32'h00, "mask_rst"));
    tbl.push_back(mk(3'd0, 1'b0, 32'h0,        6'h00, 3'd2, 32'h3F, "mode_rst"));
    tbl.push_back(mk(3'd0, 1'b0, 32'h0,        6'h00, 3'd3, 32'h07, "claim_rst"));
    tbl.push_back(mk(3'd1, 1'b1, 32'hFFFFFFFF, 6'h00, 3'd1, 32'h3F, "mask_wr"));
    tbl.push_back(mk(3'd2, 1'b1, 32'hFFFFFFC5, 6'h00, 3'd2, 32'h05, "mode_wr"));
    tbl.push_back(mk(3'd5, 1'b1, 32'hFFFFFFFF, 6'h00, 3'd5, 32'h00, "off5_rd"));
    tbl.push_back(mk(3'd0, 1'b0, 32'h0,        6'h00, 3'd1, 32'h3F, "mask_keep"));
    tbl.push_back(mk(3'd0, 1'b0, 32'h0,        6'h00, 3'd2, 32'h05, "mode_keep"));
    tbl.push_back(mk(3'd0, 1'b0, 32'h0,        6'h00, 3'd7, 32'h00, "off7_rd"));
    tbl.push_back(mk(3'd0, 1'b0, 32'h0,        6'h00, 3'd4, 32'h00, "eoi_rd"));
    tbl.push_back(mk(3'd0, 1'b0, 32'h0,        6'h0A, 3'd0, 32'h0A, "pend_level"));
    tbl.push_back(mk(3'd0, 1'b1, 32'h3F,       6'h08, 3'd0, 32'h08, "pend_lvl_w1c"));
    tbl.push_back(mk(3'd0, 1'b0, 32'h0,        6'h09, 3'd0, 32'h09, "pend_edge"));
    tbl.push_back(mk(3'd0, 1'b1, 32'h01,       6'h08, 3'd0, 32'h08, "pend_edge_w1c"));
    tbl.push_back(mk(3'd0, 1'b0, 32'h0,        6'h00, 3'd0, 32'h00, "pend_clear"));

    // Reset state, checked while reset is held.
    reset = 1'b1; src = '0; WE = 1'b0; Din = '0; Addr = '0; irq_ack = 1'b0;
    #2;
    chk("rst_req", 32'(irq_req), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    chk("rst_hwint", 32'(hwint), 32'd0);
    chk_rd("rst_pend", 3'd0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    foreach (tbl[k]) begin
      v    = tbl[k];
      src  = v.src;
      Addr = {27'd0, v.addr};
      WE   = v.we;
      Din  = v.din;
      tick();
      WE   = 1'b0;
      rd(v.raddr, d);
      chk(v.name, d, v.exp);
    end

    // 1: one-cycle pulse on src[1] is requested two edges later.
    do_reset();
    wr(3'd1, 32'h3F);
    src = 6'h02;
    tick();
    src = 6'h00;
    chk("s1_req_early", 32'(irq_req), 32'd0);
    tick();
    chk("s1_req", 32'(irq_req), 32'd1);
    chk("s1_id", 32'(irq_id), 32'd1);
    chk_rd("s1_pend", 3'd0, 32'h02);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("s1_req_ack", 32'(irq_req), 32'd0);
    chk_rd("s1_claim", 3'd3, 32'd1);
    chk_rd("s1_pend_clr", 3'd0, 32'h0);
    wr(3'd4, 32'd1);
    chk_rd("s1_eoi", 3'd3, 32'd7);

    // 2: higher-priority arrival pre-empts a pending request.
    do_reset();
    wr(3'd1, 32'h3F);
    src = 6'h08; tick(); src = 6'h00; tick();
    chk("s2_id3", 32'(irq_id), 32'd3);
    src = 6'h01; tick(); src = 6'h00; tick();
    chk("s2_req", 32'(irq_req), 32'd1);
    chk("s2_id0", 32'(irq_id), 32'd0);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk_rd("s2_claim", 3'd3, 32'd0);
    chk_rd("s2_pend", 3'd0, 32'h08);

    // 3: mismatched EOI ignored; matching EOI releases and re-arbitrates.
    do_reset();
    wr(3'd1, 32'h3F);
    src = 6'h04; tick(); src = 6'h00; tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    src = 6'h10; tick(); src = 6'h00;
    chk("s3_svc_noreq", 32'(irq_req), 32'd0);
    wr(3'd4, 32'd5);
    chk_rd("s3_eoi_bad", 3'd3, 32'd2);
    chk("s3_bad_noreq", 32'(irq_req), 32'd0);
    wr(3'd4, 32'd2);
    chk_rd("s3_eoi_ok", 3'd3, 32'd7);
    chk("s3_idle_noreq", 32'(irq_req), 32'd0);
    tick();
    chk("s3_rereq", 32'(irq_req), 32'd1);
    chk("s3_id4", 32'(irq_id), 32'd4);

    // 4: level source is re-requested after EOI until it drops.
    do_reset();
    wr(3'd1, 32'h3F);
    wr(3'd2, 32'h3B);
    src = 6'h04; tick(); tick();
    chk("s4_req", 32'(irq_req), 32'd1);
    chk("s4_id", 32'(irq_id), 32'd2);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk_rd("s4_pend_lvl", 3'd0, 32'h04);
    wr(3'd4, 32'd2);
    tick();
    chk("s4_rereq", 32'(irq_req), 32'd1);
    chk("s4_reid", 32'(irq_id), 32'd2);
    src = 6'h00;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    wr(3'd4, 32'd2);
    tick();
    chk("s4_dropped", 32'(irq_req), 32'd0);

    // 5: set beats same-cycle W1C; masking during REQ drops the request.
    do_reset();
    wr(3'd1, 32'h3F);
    src = 6'h08;
    wr(3'd0, 32'h08);
    src = 6'h00;
    chk_rd("s5_set_wins", 3'd0, 32'h08);
    tick();
    chk("s5_req", 32'(irq_req), 32'd1);
    wr(3'd1, 32'h00);
    chk("s5_req_hold", 32'(irq_req), 32'd1);
    chk("s5_hwint", 32'(hwint), 32'd0);
    tick();
    chk("s5_req_fall", 32'(irq_req), 32'd0);

    // 6: asynchronous reset in REQ and in SERVICE.
    do_reset();
    wr(3'd1, 32'h3F);
    src = 6'h04; tick(); src = 6'h00; tick();
    chk("s6_in_req", 32'(irq_id), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("s6r_req", 32'(irq_req), 32'd0);
    chk("s6r_id", 32'(irq_id), 32'd0);
    chk("s6r_hwint", 32'(hwint), 32'd0);
    chk_rd("s6r_pend", 3'd0, 32'h0);
    chk_rd("s6r_claim", 3'd3, 32'd7);
    @(negedge clk);
    reset = 1'b0;
    tick();
    wr(3'd1, 32'h3F);
    src = 6'h02; tick(); src = 6'h00; tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    src = 6'h20; tick(); src = 6'h00;
    chk("s6_svc_hwint", 32'(hwint), 32'h20);
    #2;
    reset = 1'b1;
    #1;
    chk("s6s_req", 32'(irq_req), 32'd0);
    chk("s6s_id", 32'(irq_id), 32'd0);
    chk("s6s_hwint", 32'(hwint), 32'd0);
    chk_rd("s6s_claim", 3'd3, 32'd7);
    chk_rd("s6s_mask", 3'd1, 32'h0);
    chk_rd("s6s_mode", 3'd2, 32'h3F);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Randomized traffic against the behavioural model.
    do_reset();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      bit [5:0]  s;
      bit        w;
      bit        ack;
      int        a;
      int        op;
      bit [31:0] dd;
      s   = 6'($urandom_range(0, 63));
      ack = ($urandom_range(0, 3) == 0);
      op  = $urandom_range(0, 9);
      dd  = $urandom;
      w   = 1'b1;
      case (op)
        0: a = 0;
        1: begin a = 1; dd = dd | $urandom; end
        2: a = 2;
        3, 4: begin
          a = 4;
          if ($urandom_range(0, 1) == 1) dd[2:0] = 3'(m_claim);
        end
        default: begin a = $urandom_range(0, 7); w = 1'b0; end
      endcase
      src     = s;
      Addr    = {27'd0, 3'(a)};
      WE      = w;
      Din     = dd;
      irq_ack = ack;
      model_step(s, w, a, dd, ack);
      tick();
      chk("rnd_req", 32'(irq_req), 32'(m_req));
      if (m_req) chk("rnd_id", 32'(irq_id), 32'(m_id));
      chk("rnd_hwint", 32'(hwint), 32'(m_pend & m_mask));
      chk("rnd_dout", Dout, model_read(a));
    end
    WE = 1'b0;
    irq_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
